// File: rtl/pu_riscv_biu_arbiter.sv
// N-port arbiter in front of one BIU: fixed-priority or round-robin grant, holds
// the bus for bursts and locked sequences. Optional watchdog: PU_RISCV_ARB_WATCHDOG_EN.
module pu_riscv_biu_arbiter #(
  parameter int XLEN     = 64,
  parameter int PLEN     = 64,
  parameter int PORTS    = 4,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [PORTS-1:0]      biu_req_i,
  output logic [PORTS-1:0]      biu_req_ack_o,
  output logic [PORTS-1:0]      biu_d_ack_o,
  input  logic [PORTS*PLEN-1:0] biu_adri_i,
  output logic [PORTS*PLEN-1:0] biu_adro_o,
  input  logic [PORTS*3-1:0]    biu_size_i,
  input  logic [PORTS*3-1:0]    biu_type_i,
  input  logic [PORTS*3-1:0]    biu_prot_i,
  input  logic [PORTS-1:0]      biu_lock_i,
  input  logic [PORTS-1:0]      biu_we_i,
  input  logic [PORTS*XLEN-1:0] biu_d_i,
  output logic [PORTS*XLEN-1:0] biu_q_o,
  output logic [PORTS-1:0]      biu_ack_o,
  output logic [PORTS-1:0]      biu_err_o,
  output logic                  biu_req_o,
  output logic [PLEN-1:0]       biu_adri_o,
  output logic [2:0]            biu_size_o,
  output logic [2:0]            biu_type_o,
  output logic                  biu_lock_o,
  output logic [2:0]            biu_prot_o,
  output logic                  biu_we_o,
  output logic [XLEN-1:0]       biu_d_o,
  input  logic                  biu_req_ack_i,
  input  logic                  biu_d_ack_i,
  input  logic [PLEN-1:0]       biu_adro_i,
  input  logic [XLEN-1:0]       biu_q_i,
  input  logic                  biu_ack_i,
  input  logic                  biu_err_i
);

  localparam int PW = $clog2(PORTS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BURST  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]      fsm;
  logic [PW-1:0]   owner, last_grant;
  logic [PW-1:0]   fp_grant, rr_grant, grant, sel;
  logic [3:0]      beat_cnt, new_cnt;
  logic            hold, final_beat, open, accept, term, wdog_to;

  logic [PLEN-1:0] adri  [PORTS];
  logic [2:0]      size  [PORTS];
  logic [2:0]      btype [PORTS];
  logic [2:0]      prot  [PORTS];
  logic [XLEN-1:0] wdat  [PORTS];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign adri[p]  = biu_adri_i[p*PLEN +: PLEN];
    assign size[p]  = biu_size_i[p*3 +: 3];
    assign btype[p] = biu_type_i[p*3 +: 3];
    assign prot[p]  = biu_prot_i[p*3 +: 3];
    assign wdat[p]  = biu_d_i[p*XLEN +: XLEN];
  end

  function automatic logic [3:0] beats_m1(input logic [2:0] t);
    case (t)
      3'd2, 3'd3: return 4'd3;
      3'd4, 3'd5: return 4'd7;
      3'd6, 3'd7: return 4'd15;
      default:    return 4'd0;
    endcase
  endfunction

  // Iterating downwards lets the lowest index / nearest RR offset win.
  always_comb begin
    int            idx;
    logic [PW-1:0] pi;
    idx      = 0;
    pi       = '0;
    fp_grant = last_grant;
    rr_grant = last_grant;
    for (int i = PORTS-1; i >= 0; i--) begin
      pi = PW'(i);
      if (biu_req_i[pi]) fp_grant = pi;
    end
    for (int k = PORTS; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      pi = PW'(idx);
      if (biu_req_i[pi]) rr_grant = pi;
    end
  end

  assign hold       = (fsm == LOCKED) || ((fsm == BURST) && biu_lock_i[owner]);
  assign grant      = hold ? owner : ((ARB_MODE != 0) ? rr_grant : fp_grant);
  assign final_beat = (fsm == BURST) && (beat_cnt == 4'd0) && biu_ack_i && !biu_err_i;
  // The address phase is open outside bursts and on the last beat, allowing a same-cycle re-grant.
  assign open       = (fsm != BURST) || final_beat;
  assign sel        = open ? grant : owner;
  assign biu_req_o  = open && biu_req_i[sel];
  assign accept     = biu_req_o && biu_req_ack_i;
  assign new_cnt    = beats_m1(btype[sel]);
  assign term       = (fsm == BURST) && (final_beat || biu_err_i || wdog_to);

  assign biu_adri_o = adri[sel];
  assign biu_size_o = size[sel];
  assign biu_type_o = btype[sel];
  assign biu_prot_o = prot[sel];
  assign biu_lock_o = biu_lock_i[sel];
  assign biu_we_o   = biu_we_i[sel];
  assign biu_d_o    = wdat[sel];

  assign biu_adro_o = {PORTS{biu_adro_i}};
  assign biu_q_o    = {PORTS{biu_q_i}};

  always_comb begin
    biu_req_ack_o        = '0;
    biu_ack_o            = '0;
    biu_err_o            = '0;
    biu_d_ack_o          = '0;
    biu_req_ack_o[sel]   = biu_req_ack_i;
    biu_ack_o[owner]     = biu_ack_i;
    biu_err_o[owner]     = biu_err_i | wdog_to;
    biu_d_ack_o[owner]   = biu_d_ack_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm        <= IDLE;
      owner      <= '0;
      last_grant <= PW'(PORTS-1);
      beat_cnt   <= '0;
    end else if (accept) begin
      owner      <= sel;
      last_grant <= sel;
      beat_cnt   <= new_cnt;
      if (new_cnt != 4'd0)     fsm <= BURST;
      else if (biu_lock_i[sel]) fsm <= LOCKED;
      else                      fsm <= IDLE;
    end else begin
      case (fsm)
        BURST: begin
          if (term)           fsm <= (biu_lock_i[owner] && !wdog_to) ? LOCKED : IDLE;
          else if (biu_ack_i) beat_cnt <= beat_cnt - 4'd1;
        end
        LOCKED:  if (!biu_lock_i[owner] && !biu_req_i[owner]) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef PU_RISCV_ARB_WATCHDOG_EN
  logic [7:0] wdog;

  // Counts stalled burst cycles; expiry aborts the burst and drops any lock.
  assign wdog_to = (fsm == BURST) && !biu_ack_i && (wdog == 8'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                    wdog <= '0;
    else if (fsm != BURST || biu_ack_i || wdog_to) wdog <= '0;
    else                                            wdog <= wdog + 8'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^(8'(TIMEOUT));
  assign wdog_to        = 1'b0;
`endif

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Scoreboard bench for pu_riscv_biu_arbiter: fixed-priority and round-robin instances
// share stimulus; a negedge monitor checks the selected instance's response events.
module tb_pu_riscv_biu_arbiter;
  localparam int XLEN  = 64;
  localparam int PLEN  = 64;
  localparam int PORTS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [PORTS-1:0]      req, lock, we;
  logic [PORTS*PLEN-1:0] adri;
  logic [PORTS*3-1:0]    size, btype, prot;
  logic [PORTS*XLEN-1:0] wd;
  logic                  req_ack_i, d_ack_i, ack_i, err_i;
  logic [PLEN-1:0]       adro_i;
  logic [XLEN-1:0]       q_i;

  logic [PORTS-1:0]      rack [2];
  logic [PORTS-1:0]      dack [2];
  logic [PORTS-1:0]      ack  [2];
  logic [PORTS-1:0]      err  [2];
  logic [PORTS*PLEN-1:0] adro_o [2];
  logic [PORTS*XLEN-1:0] q_o  [2];
  logic                  req_o [2];
  logic [PLEN-1:0]       adr_o [2];
  logic [2:0]            size_o [2];
  logic [2:0]            type_o [2];
  logic                  lock_o [2];
  logic [2:0]            prot_o [2];
  logic                  we_o [2];
  logic [XLEN-1:0]       d_o [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    pu_riscv_biu_arbiter #(
      .XLEN(XLEN), .PLEN(PLEN), .PORTS(PORTS), .ARB_MODE(m), .TIMEOUT(16)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .biu_req_i(req), .biu_req_ack_o(rack[m]), .biu_d_ack_o(dack[m]),
      .biu_adri_i(adri), .biu_adro_o(adro_o[m]),
      .biu_size_i(size), .biu_type_i(btype), .biu_prot_i(prot),
      .biu_lock_i(lock), .biu_we_i(we), .biu_d_i(wd), .biu_q_o(q_o[m]),
      .biu_ack_o(ack[m]), .biu_err_o(err[m]),
      .biu_req_o(req_o[m]), .biu_adri_o(adr_o[m]), .biu_size_o(size_o[m]),
      .biu_type_o(type_o[m]), .biu_lock_o(lock_o[m]), .biu_prot_o(prot_o[m]),
      .biu_we_o(we_o[m]), .biu_d_o(d_o[m]),
      .biu_req_ack_i(req_ack_i), .biu_d_ack_i(d_ack_i), .biu_adro_i(adro_i),
      .biu_q_i(q_i), .biu_ack_i(ack_i), .biu_err_i(err_i)
    );
  end

  typedef struct {
    string       nm;
    logic [3:0]  rack, ack, err;
    logic        req;
    logic [63:0] adr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  bit   mode;
  int   checks = 0;
  int   failures = 0;
  int   wn;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input string nm, input logic [3:0] ra, input logic [3:0] ak,
                           input logic [3:0] er, input logic rq, input logic [63:0] ad);
    exp_t x;
    x.nm = nm; x.rack = ra; x.ack = ak; x.err = er; x.req = rq; x.adr = ad;
    exp_q.push_back(x);
  endtask

  // Any response activity on the selected instance must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (|rack[mode] || |ack[mode] || |err[mode])) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: rack=%b ack=%b err=%b, none expected",
                 rack[mode], ack[mode], err[mode]);
      end else begin
        mx = exp_q.pop_front();
        if (rack[mode] !== mx.rack || ack[mode] !== mx.ack || err[mode] !== mx.err ||
            req_o[mode] !== mx.req || (mx.req && adr_o[mode] !== mx.adr)) begin
          failures++;
          $display("FAIL %s: rack=%b ack=%b err=%b req=%b adr=%0h expected rack=%b ack=%b err=%b req=%b adr=%0h",
                   mx.nm, rack[mode], ack[mode], err[mode], req_o[mode], adr_o[mode],
                   mx.rack, mx.ack, mx.err, mx.req, mx.adr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    req = '0; req_ack_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; d_ack_i = 1'b0;
    lock = '0; btype = '0;
  endtask

  task automatic cyc(input logic [3:0] r, input logic ra, input logic a, input logic e);
    step();
    req = r; req_ack_i = ra; ack_i = a; err_i = e; d_ack_i = 1'b0;
  endtask

  task automatic set_type(input int p, input logic [2:0] t);
    btype[p*3 +: 3] = t;
  endtask

  task automatic do_reset(input bit m);
    step(); idle_in(); rst_n = 1'b0;
    step(); step(); rst_n = 1'b1; mode = m;
  endtask

  logic [3:0] rr_rack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_ack  [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [63:0] rr_adr [5] = '{64'h1000, 64'h2000, 64'h3000, 64'h4000, 64'h1000};

  initial begin
    #100000;
    $display("FAIL sim_timeout: run did not complete");
    $fatal(1);
  end

  initial begin
    adri = {64'h4000, 64'h3000, 64'h2000, 64'h1000};
    prot = {3'd4, 3'd3, 3'd2, 3'd1};
    size = {4{3'd3}};
    we   = 4'b0001;
    wd   = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
    adro_i = '0; q_i = '0; mode = 1'b0;
    idle_in();
    rst_n = 1'b0;
    step(); step(); #1;
    chk("reset_req_o", req_o[0], 0);
    chk("reset_rack", rack[0], 0);
    chk("reset_ack_rr", ack[1], 0);
    rst_n = 1'b1;

    // T1 fixed priority: port0 beats port2, then port2
    cyc(4'b0101, 1, 0, 0);
    expect_ev("t1_grant0", 4'b0001, 4'b0000, 4'b0000, 1, 64'h1000);
    #1;
    chk("t1_prot", prot_o[0], 3'd1);
    chk("t1_we", we_o[0], 1);
    chk("t1_wdata", d_o[0], 64'hAAAA);
    cyc(4'b0100, 1, 1, 0);
    expect_ev("t1_grant2", 4'b0100, 4'b0001, 4'b0000, 1, 64'h3000);
    #1 chk("t1_prot2", prot_o[0], 3'd3);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("t1_ack2", 4'b0000, 4'b0100, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 0);

    // T2 round robin over all four ports
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 1, (i > 0), 0);
      expect_ev($sformatf("t2_rr%0d", i), rr_rack[i], rr_ack[i], 4'b0000, 1, rr_adr[i]);
    end
    cyc(4'b0000, 0, 1, 0);
    expect_ev("t2_last_ack", 4'b0000, 4'b0001, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 0);

    // T3 INCR4 on port1, port0 waits and is re-granted on the 4th ack
    do_reset(0);
    set_type(1, 3'd3);
    q_i = 64'h5A5A;
    cyc(4'b0010, 1, 0, 0);
    expect_ev("t3_grant1", 4'b0010, 4'b0000, 4'b0000, 1, 64'h2000);
    cyc(4'b0000, 0, 1, 0);
    d_ack_i = 1'b1;
    expect_ev("t3_beat1", 4'b0000, 4'b0010, 4'b0000, 0, 64'h0);
    #1;
    chk("t3_dack", dack[0], 4'b0010);
    chk("t3_q_bcast", q_o[0], {4{64'h5A5A}});
    cyc(4'b0001, 0, 1, 0);
    expect_ev("t3_beat2", 4'b0000, 4'b0010, 4'b0000, 0, 64'h0);
    #1 chk("t3_blocked", req_o[0], 0);
    cyc(4'b0001, 0, 0, 0);
    #1 chk("t3_hold_adr", adr_o[0], 64'h2000);
    cyc(4'b0001, 0, 1, 0);
    expect_ev("t3_beat3", 4'b0000, 4'b0010, 4'b0000, 0, 64'h0);
    cyc(4'b0001, 1, 1, 0);
    expect_ev("t3_regrant", 4'b0001, 4'b0010, 4'b0000, 1, 64'h1000);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("t3_ack0", 4'b0000, 4'b0001, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 0);
    set_type(1, 3'd0);

    // T4 locked sequence on port2 starves port0
    do_reset(0);
    cyc(4'b0100, 1, 0, 0);
    lock = 4'b0100;
    expect_ev("t4_lock_grant", 4'b0100, 4'b0000, 4'b0000, 1, 64'h3000);
    cyc(4'b0101, 1, 1, 0);
    expect_ev("t4_locked_grant", 4'b0100, 4'b0100, 4'b0000, 1, 64'h3000);
    cyc(4'b0001, 0, 1, 0);
    lock = 4'b0000;
    expect_ev("t4_ack2", 4'b0000, 4'b0100, 4'b0000, 0, 64'h0);
    cyc(4'b0001, 1, 0, 0);
    expect_ev("t4_grant0", 4'b0001, 4'b0000, 4'b0000, 1, 64'h1000);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("t4_ack0", 4'b0000, 4'b0001, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 0);

    // T5 WRAP8 on port3 aborted by error; then ack+err in one cycle
    do_reset(0);
    set_type(3, 3'd4);
    cyc(4'b1000, 1, 0, 0);
    expect_ev("t5_grant3", 4'b1000, 4'b0000, 4'b0000, 1, 64'h4000);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("t5_beat1", 4'b0000, 4'b1000, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("t5_beat2", 4'b0000, 4'b1000, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 1);
    expect_ev("t5_err", 4'b0000, 4'b0000, 4'b1000, 0, 64'h0);
    cyc(4'b0001, 1, 0, 0);
    expect_ev("t5_idle_after_err", 4'b0001, 4'b0000, 4'b0000, 1, 64'h1000);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("t5_ack0", 4'b0000, 4'b0001, 4'b0000, 0, 64'h0);
    cyc(4'b1000, 1, 0, 0);
    expect_ev("t5_regrant3", 4'b1000, 4'b0000, 4'b0000, 1, 64'h4000);
    cyc(4'b0000, 0, 1, 1);
    expect_ev("t5_ack_err", 4'b0000, 4'b1000, 4'b1000, 0, 64'h0);
    cyc(4'b0010, 1, 0, 0);
    expect_ev("t5_idle_after_ackerr", 4'b0010, 4'b0000, 4'b0000, 1, 64'h2000);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("t5_ack1", 4'b0000, 4'b0010, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 0);
    set_type(3, 3'd0);

    // Reset in the middle of an INCR16
    do_reset(0);
    set_type(1, 3'd7);
    cyc(4'b0010, 1, 0, 0);
    expect_ev("rst_grant1", 4'b0010, 4'b0000, 4'b0000, 1, 64'h2000);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("rst_beat1", 4'b0000, 4'b0010, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rack", rack[0], 0);
    chk("rst_mid_ack", ack[0], 0);
    chk("rst_mid_err", err[0], 0);
    chk("rst_mid_dack", dack[0], 0);
    chk("rst_mid_req", req_o[0], 0);
    step(); rst_n = 1'b1;
    cyc(4'b0100, 1, 0, 0);
    expect_ev("rst_idle_grant2", 4'b0100, 4'b0000, 4'b0000, 1, 64'h3000);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("rst_ack2", 4'b0000, 4'b0100, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 0);
    set_type(1, 3'd0);

`ifdef PU_RISCV_ARB_WATCHDOG_EN
    // Watchdog: INCR8 on port0 never acked
    do_reset(0);
    set_type(0, 3'd5);
    cyc(4'b0001, 1, 0, 0);
    expect_ev("wd_grant0", 4'b0001, 4'b0000, 4'b0000, 1, 64'h1000);
    expect_ev("wd_err", 4'b0000, 4'b0000, 4'b0001, 0, 64'h0);
    wn = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc(4'b0000, 0, 0, 0);
      wn = n;
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    chk("wd_cycle", wn, 17);
    set_type(0, 3'd0);
    cyc(4'b0010, 1, 0, 0);
    expect_ev("wd_idle_grant1", 4'b0010, 4'b0000, 4'b0000, 1, 64'h2000);
    cyc(4'b0000, 0, 1, 0);
    expect_ev("wd_ack1", 4'b0000, 4'b0010, 4'b0000, 0, 64'h0);
    cyc(4'b0000, 0, 0, 0);
`endif

    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
